// File: rtl/analog_mux_sched_pkg.sv
// Shared types and helpers for the analog mux scheduler.
package analog_mux_pkg;

    localparam int unsigned AMUX_MAX_NCH = 8;

    typedef enum logic [1:0] {
        IDLE,
        BREAK,
        SETTLE,
        GRANT
    } amux_state_t;

    // Largest of three interval parameters; sizes the shared down-counter.
    function automatic int unsigned amux_max3(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/analog_mux_sched_rr_pick.sv
// Round-robin picker: first set request at or after ptr, in modular order.
module rr_pick #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] idx_o,
    output logic            valid_o
);

    logic [NCH-1:0] rot;
    int unsigned    pos;

    // Rotate requests so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot     = NCH'({req_i, req_i} >> ptr_i);
        idx_o   = '0;
        valid_o = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!valid_o && rot[k]) begin
                valid_o = 1'b1;
                pos     = 32'(ptr_i) + k;
                if (pos >= NCH) pos = pos - NCH;
                idx_o   = SELW'(pos);
            end
        end
    end

endmodule

// File: rtl/analog_mux_sched.sv
// Shares one analog mux between NCH requesters with break-before-make
// dead time and a settling interval before grant.
module analog_mux_sched
    import analog_mux_pkg::*;
#(
    parameter int unsigned NCH        = 2,
    parameter int unsigned SELW       = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int unsigned DEAD_CYC   = 2,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned HOLD_MAX   = 0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NCH-1:0]  req,
    input  logic            ana_ok,
    output logic [SELW-1:0] sel,
    output logic            en,
    output logic [NCH-1:0]  gnt,
    output logic            busy,
    output logic            timeout
);

    localparam int unsigned CNT_MAX = amux_max3(DEAD_CYC, SETTLE_CYC, HOLD_MAX);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    amux_state_t     state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic            en_q, en_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic [SELW-1:0] pick_idx;
    logic            pick_valid;
    logic            req_win;
    logic            cnt_last;
    logic            hold_expire;
    logic [SELW-1:0] next_ptr;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign req_win     = req[sel_q];
    assign cnt_last    = (cnt_q <= CNT_W'(1));
    assign hold_expire = (HOLD_MAX != 0) && cnt_last;
    assign next_ptr    = (sel_q == SELW'(NCH - 1)) ? '0 : sel_q + SELW'(1);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; supply loss overrides everything.
    always_comb begin
        state_d = state_q;
        if (!ana_ok) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (pick_valid) state_d = BREAK;
                BREAK:   if (!req_win) state_d = IDLE;
                         else if (cnt_last) state_d = SETTLE;
                SETTLE:  if (!req_win) state_d = IDLE;
                         else if (cnt_last) state_d = GRANT;
                GRANT:   if (!req_win || hold_expire) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output and datapath next values, keyed on the transition taken.
    always_comb begin
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        en_d      = en_q;
        timeout_d = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (state_d == BREAK) begin
                    sel_d = pick_idx;
                    cnt_d = CNT_W'(DEAD_CYC);
                end
            end
            BREAK: begin
                if (state_d == SETTLE) begin
                    en_d  = 1'b1;
                    cnt_d = CNT_W'(SETTLE_CYC);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (state_d == GRANT) begin
                    gnt_d = NCH'(1) << sel_q;
                    cnt_d = CNT_W'(HOLD_MAX);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GRANT: begin
                if (state_d == IDLE) begin
                    ptr_d     = next_ptr;
                    // Still requested and supply good: only a hold expiry releases.
                    timeout_d = ana_ok && req_win;
                end else if (HOLD_MAX != 0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (state_d == IDLE) begin
            en_d  = 1'b0;
            gnt_d = '0;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sel_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_analog_mux_sched.sv
// Scoreboard bench: stimulus queues expected output transitions, monitors
// pop and compare whenever a DUT output vector changes.
module tb_analog_mux_sched;

    typedef struct packed {
        int         cyc;
        logic       sel;
        logic       en;
        logic [1:0] gnt;
        logic       busy;
        logic       to;
    } evt_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] req_a, req_b;
    logic       ana_a, ana_b;
    logic       sel_a, sel_b, en_a, en_b, busy_a, busy_b, to_a, to_b;
    logic [1:0] gnt_a, gnt_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    evt_t q_a[$];
    evt_t q_b[$];

    analog_mux_sched #(
        .NCH(2), .SELW(1), .DEAD_CYC(2), .SETTLE_CYC(8), .HOLD_MAX(0)
    ) u_dut_a (
        .clk(clk), .resetn(resetn), .req(req_a), .ana_ok(ana_a),
        .sel(sel_a), .en(en_a), .gnt(gnt_a), .busy(busy_a), .timeout(to_a)
    );

    analog_mux_sched #(
        .NCH(2), .SELW(1), .DEAD_CYC(2), .SETTLE_CYC(8), .HOLD_MAX(5)
    ) u_dut_b (
        .clk(clk), .resetn(resetn), .req(req_b), .ana_ok(ana_b),
        .sel(sel_b), .en(en_b), .gnt(gnt_b), .busy(busy_b), .timeout(to_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic score(input string nm, input bit has, input evt_t want, input evt_t got);
        checks++;
        if (!has) begin
            errors++;
            $display("FAIL %s unexpected cyc=%0d sel=%0d en=%0d gnt=%b busy=%0d to=%0d",
                     nm, got.cyc, got.sel, got.en, got.gnt, got.busy, got.to);
        end else if (want !== got) begin
            errors++;
            $display("FAIL %s got cyc=%0d sel=%0d en=%0d gnt=%b busy=%0d to=%0d, want cyc=%0d sel=%0d en=%0d gnt=%b busy=%0d to=%0d",
                     nm, got.cyc, got.sel, got.en, got.gnt, got.busy, got.to,
                     want.cyc, want.sel, want.en, want.gnt, want.busy, want.to);
        end
    endtask

    task automatic push_a(input int c, input logic s, input logic e,
                          input logic [1:0] g, input logic b, input logic t);
        q_a.push_back('{c, s, e, g, b, t});
    endtask

    task automatic push_b(input int c, input logic s, input logic e,
                          input logic [1:0] g, input logic b, input logic t);
        q_b.push_back('{c, s, e, g, b, t});
    endtask

    // Advance to 1 ns after edge t (returns at once if already there).
    task automatic goto_edge(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor for DUT A: event on any output change, plus break-before-make.
    logic [5:0] prev_a = '0;
    logic       psel_a = 1'b0, pen_a = 1'b0;
    always @(negedge clk) begin
        evt_t obs, w;
        bit   has;
        obs = '{cyc, sel_a, en_a, gnt_a, busy_a, to_a};
        if (mon_on && ({sel_a, en_a, gnt_a, busy_a, to_a} != prev_a)) begin
            has = (q_a.size() > 0);
            w   = has ? q_a.pop_front() : '0;
            score("a_evt", has, w, obs);
        end
        if (mon_on && resetn && (sel_a != psel_a)) begin
            checks++;
            if (pen_a || en_a) begin
                errors++;
                $display("FAIL a_bbm sel changed with en prev=%0d now=%0d (cyc %0d)", pen_a, en_a, cyc);
            end
        end
        prev_a = {sel_a, en_a, gnt_a, busy_a, to_a};
        psel_a = sel_a;
        pen_a  = en_a;
    end

    // Monitor for DUT B.
    logic [5:0] prev_b = '0;
    logic       psel_b = 1'b0, pen_b = 1'b0;
    always @(negedge clk) begin
        evt_t obs, w;
        bit   has;
        obs = '{cyc, sel_b, en_b, gnt_b, busy_b, to_b};
        if (mon_on && ({sel_b, en_b, gnt_b, busy_b, to_b} != prev_b)) begin
            has = (q_b.size() > 0);
            w   = has ? q_b.pop_front() : '0;
            score("b_evt", has, w, obs);
        end
        if (mon_on && resetn && (sel_b != psel_b)) begin
            checks++;
            if (pen_b || en_b) begin
                errors++;
                $display("FAIL b_bbm sel changed with en prev=%0d now=%0d (cyc %0d)", pen_b, en_b, cyc);
            end
        end
        prev_b = {sel_b, en_b, gnt_b, busy_b, to_b};
        psel_b = sel_b;
        pen_b  = en_b;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0;
        req_a  = 2'b00;
        req_b  = 2'b00;
        ana_a  = 1'b1;
        ana_b  = 1'b1;
        goto_edge(3);
        chk("rst_sel_a", sel_a, 0);
        chk("rst_en_a", en_a, 0);
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_to_a", to_a, 0);
        chk("rst_busy_b", busy_b, 0);
        goto_edge(4);
        resetn = 1'b1;
        mon_on = 1'b1;

        // Single request on input 0; drop after ten granted cycles.
        goto_edge(cyc + 2);
        req_a = 2'b01;
        n = cyc + 1;
        push_a(n,      0, 0, 2'b00, 1, 0);
        push_a(n + 2,  0, 1, 2'b00, 1, 0);
        push_a(n + 10, 0, 1, 2'b01, 1, 0);
        goto_edge(n + 19);
        req_a = 2'b00;
        push_a(n + 20, 0, 0, 2'b00, 0, 0);

        // Abort in SETTLE: ptr stays at 1, so 11 grants input 1 first.
        goto_edge(n + 24);
        req_a = 2'b10;
        n = cyc + 1;
        push_a(n,     1, 0, 2'b00, 1, 0);
        push_a(n + 2, 1, 1, 2'b00, 1, 0);
        goto_edge(n + 4);
        req_a = 2'b00;
        push_a(n + 5, 1, 0, 2'b00, 0, 0);
        goto_edge(n + 8);
        req_a = 2'b11;
        n = cyc + 1;
        push_a(n,      1, 0, 2'b00, 1, 0);
        push_a(n + 2,  1, 1, 2'b00, 1, 0);
        push_a(n + 10, 1, 1, 2'b10, 1, 0);

        // Supply loss in GRANT, then requests with supply down stay idle.
        goto_edge(n + 12);
        ana_a = 1'b0;
        push_a(n + 13, 1, 0, 2'b00, 0, 0);
        for (int i = 0; i < 6; i++) begin
            goto_edge(cyc + 1);
            chk("a_busy_nosupply", busy_a, 0);
        end

        // Supply back: pointer advanced past 1, so input 0 wins.
        goto_edge(n + 20);
        ana_a = 1'b1;
        n = cyc + 1;
        push_a(n,      0, 0, 2'b00, 1, 0);
        push_a(n + 2,  0, 1, 2'b00, 1, 0);
        push_a(n + 10, 0, 1, 2'b01, 1, 0);
        goto_edge(n + 14);
        req_a = 2'b10;
        push_a(n + 15, 0, 0, 2'b00, 0, 0);
        push_a(n + 16, 1, 0, 2'b00, 1, 0);
        push_a(n + 18, 1, 1, 2'b00, 1, 0);
        push_a(n + 26, 1, 1, 2'b10, 1, 0);

        // Asynchronous reset mid-GRANT, between clock edges.
        goto_edge(n + 28);
        push_a(cyc, 0, 0, 2'b00, 0, 0);
        #2 resetn = 1'b0;
        #1;
        chk("a_arst_sel", sel_a, 0);
        chk("a_arst_en", en_a, 0);
        chk("a_arst_gnt", gnt_a, 0);
        chk("a_arst_busy", busy_a, 0);
        req_a = 2'b00;
        goto_edge(cyc + 3);
        resetn = 1'b1;

        // Fairness under HOLD_MAX=5 with both requesting continuously.
        goto_edge(cyc + 2);
        req_b = 2'b11;
        n = cyc + 1;
        push_b(n,      0, 0, 2'b00, 1, 0);
        push_b(n + 2,  0, 1, 2'b00, 1, 0);
        push_b(n + 10, 0, 1, 2'b01, 1, 0);
        push_b(n + 15, 0, 0, 2'b00, 0, 1);
        push_b(n + 16, 1, 0, 2'b00, 1, 0);
        push_b(n + 18, 1, 1, 2'b00, 1, 0);
        push_b(n + 26, 1, 1, 2'b10, 1, 0);
        push_b(n + 31, 1, 0, 2'b00, 0, 1);
        push_b(n + 32, 0, 0, 2'b00, 1, 0);
        push_b(n + 34, 0, 1, 2'b00, 1, 0);
        push_b(n + 42, 0, 1, 2'b01, 1, 0);
        goto_edge(n + 43);
        req_b = 2'b00;
        push_b(n + 44, 0, 0, 2'b00, 0, 0);

        // Sole requester times out and is re-granted after dead + settle.
        goto_edge(n + 48);
        req_b = 2'b01;
        n = cyc + 1;
        push_b(n,      0, 0, 2'b00, 1, 0);
        push_b(n + 2,  0, 1, 2'b00, 1, 0);
        push_b(n + 10, 0, 1, 2'b01, 1, 0);
        push_b(n + 15, 0, 0, 2'b00, 0, 1);
        push_b(n + 16, 0, 0, 2'b00, 1, 0);
        push_b(n + 18, 0, 1, 2'b00, 1, 0);
        push_b(n + 26, 0, 1, 2'b01, 1, 0);
        goto_edge(n + 27);
        req_b = 2'b00;
        push_b(n + 28, 0, 0, 2'b00, 0, 0);

        goto_edge(cyc + 5);
        chk("a_drain", q_a.size(), 0);
        chk("b_drain", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/analog_mux_sched.md
# analog_mux_sched

Sequences and shares one analog multiplexer between `NCH` digital requesters. Each requester owns one mux input (requester i ↔ input i). The block arbitrates round-robin and drives the mux select with break-before-make dead time. It gates the mux connection enable and grants access only after a programmable settling interval. It sits in the 1.8 V digital domain between on-chip consumers (ADC sampler, test-mode logic) and the 3.3 V analog mux's `SEL`/enable pins.

## Interface
- `NCH`, 2: number of requesters and mux inputs (2..8).
- `SELW`, `$clog2(NCH)` (min 1): select width.
- `DEAD_CYC`, 2: cycles with enable low after select changes and before connect (≥1).
- `SETTLE_CYC`, 8: cycles after connect before grant (≥1).
- `HOLD_MAX`, 0: max grant length in cycles; 0 = unlimited.
- `clk`  in  1  system clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `req`  in  NCH  per-requester access request, level.
- `ana_ok`  in  1  analog supply good; low forces disconnect.
- `sel`  out  SELW  mux select.
- `en`  out  1  mux connect enable; 0 = output isolated.
- `gnt`  out  NCH  one-hot grant, level.
- `busy`  out  1  state ≠ IDLE.
- `timeout`  out  1  one-cycle pulse on a forced `HOLD_MAX` release.

## Operation
- Reset (async, `resetn`=0): state IDLE, `sel`=0, `en`=0, `gnt`=0, `busy`=0, `timeout`=0, RR pointer=0, counter=0.
- States: IDLE, BREAK, SETTLE, GRANT. All outputs are registered.
- IDLE: `en`=0, `gnt`=0. If `ana_ok` and any `req`, pick a winner. The search starts at `ptr`; the first set bit in ascending modular order wins. Load `sel`←winner, then go to BREAK with count=DEAD_CYC.
- BREAK: `en`=0; decrement the count. At 0, go to SETTLE with `en`←1 and count=SETTLE_CYC.
- SETTLE: `en`=1; decrement the count. At 0, go to GRANT with `gnt[winner]`←1.
- GRANT: hold until `req[winner]` falls. Then `gnt`←0, `en`←0, `ptr`←winner+1 mod NCH, go to IDLE.
- If `HOLD_MAX`>0 and the grant has lasted `HOLD_MAX` cycles: release as above and pulse `timeout`.
- Abort rules:
  - `req[winner]` dropping in BREAK or SETTLE causes an immediate return to IDLE with `en`←0. `ptr` is unchanged.
  - `ana_ok` low in any state causes IDLE with `en`←0 and `gnt`←0 on the next edge. `ptr` advances only if the abort happened in GRANT.
- `sel` changes only on the IDLE→BREAK edge. At that point `en` has been 0 for ≥1 cycle, so break-before-make holds.
- `sel` holds its value in IDLE and is never X.
- Requests from non-winners are ignored until IDLE. No preemption other than the `HOLD_MAX` timeout.
- Simultaneous release and new request: the release edge always goes to IDLE. Re-arbitration happens on the following edge, so IDLE lasts ≥1 cycle.
- If only the timed-out requester is requesting, it is re-granted after a full BREAK and SETTLE.

## Timing
- `req[i]` first sampled high at edge N in IDLE:
  - `sel`=i and `busy`=1 from edge N.
  - `en` rises at edge N+DEAD_CYC.
  - `gnt[i]` rises at edge N+DEAD_CYC+SETTLE_CYC.
- `req[i]` sampled low at edge M in GRANT: `gnt`, `en` and `busy` fall at M. The earliest next `sel` change is edge M+1.
- `timeout` is high exactly one cycle, coincident with `gnt` falling.
- The counter is sized to $clog2(max(DEAD_CYC, SETTLE_CYC, HOLD_MAX)+1) bits. No wrap is possible.
- `ana_ok` and `req` are synchronous to `clk`. Synchronisers are the integrator's responsibility.

## Structure
- Package `analog_mux_pkg`: state enum `amux_state_t` {IDLE, BREAK, SETTLE, GRANT} and `AMUX_MAX_NCH`=8.
- Sub-module `rr_pick`: combinational, (`req`, `ptr`) → winner index plus valid. Reusable by other arbiters.
- The top holds the FSM, counter, pointer and output registers.

## Test plan
- Reset check: assert `resetn`=0 mid-GRANT (NCH=2, DEAD=2, SETTLE=8) → `en`, `gnt`, `busy` go to 0 and `sel` to 0 asynchronously, with no clock edge needed.
- Single request: `req`=01 at edge 10 → `sel`=0 at 10, `en`=1 at 12, `gnt`=01 at 20. Drop `req` at 30 → `gnt`=0 and `en`=0 at 30.
- Fairness: `req`=11 held continuously → grants alternate 01,10,01. Each hand-off has `en` low ≥3 cycles (1 IDLE + 2 BREAK) and `sel` changes only while `en`=0.
- Abort: drop `req[1]` during SETTLE → `en`=0 next edge, no `gnt` pulse, `ptr` unchanged, so the next `req`=11 grants 10 first.
- Timeout: HOLD_MAX=5, `req`=01 held → `gnt` high exactly 5 cycles, one-cycle `timeout` pulse, re-grant after 2+8 cycles.
- Supply loss: deassert `ana_ok` in GRANT → `en`/`gnt` 0 next edge. Requests while `ana_ok`=0 → `busy` stays 0.
